// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream, tagging every PKT_LEN-th word as packet end.
// A 2-entry skid buffer decouples fifo_rd from m_ready; reading only stops on packet boundaries.
module fifo_stream_reader #(
   parameter int B       = 8,
   parameter int PKT_LEN = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [B-1:0]     fifo_r_data,
   output logic             fifo_rd,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [B-1:0]     m_data,
   output logic             m_last,
   output logic [CNT_W-1:0] pkt_count,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

   state_t           state_q, state_d;
   logic [1:0]       count_q, count_d;
   logic [15:0]      beat_q, beat_d;
   logic [B-1:0]     hd_data_q, hd_data_d, tl_data_q, tl_data_d;
   logic             hd_last_q, hd_last_d, tl_last_q, tl_last_d;
   logic [CNT_W-1:0] pkt_q, pkt_d;

   logic push, pop, last_in;

   always_comb begin
      push    = ((state_q == RUN) || (state_q == FINISH)) && !fifo_empty && (count_q < 2'd2);
      pop     = (count_q != 2'd0) && m_ready;
      last_in = (beat_q == LAST_BEAT);

      beat_d = beat_q;
      if (push) begin
         beat_d = last_in ? '0 : beat_q + 16'd1;
      end

      hd_data_d = hd_data_q;
      hd_last_d = hd_last_q;
      tl_data_d = tl_data_q;
      tl_last_d = tl_last_q;
      count_d   = count_q;
      // Head register doubles as the output register, so it keeps its value when the queue empties.
      unique case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               hd_data_d = fifo_r_data;
               hd_last_d = last_in;
            end else begin
               tl_data_d = fifo_r_data;
               tl_last_d = last_in;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            if (count_q == 2'd2) begin
               hd_data_d = tl_data_q;
               hd_last_d = tl_last_q;
            end
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            hd_data_d = fifo_r_data;
            hd_last_d = last_in;
         end
         default: ;
      endcase

      pkt_d = pkt_q;
      if (pop && hd_last_q) begin
         pkt_d = pkt_q + CNT_W'(1);
      end

      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (enable) state_d = RUN;
         end
         RUN: begin
            if (!enable) state_d = (beat_d == 16'd0) ? IDLE : FINISH;
         end
         FINISH: begin
            if (enable) begin
               state_d = RUN;
            end else if (push && last_in) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         beat_q    <= '0;
         hd_data_q <= '0;
         hd_last_q <= 1'b0;
         tl_data_q <= '0;
         tl_last_q <= 1'b0;
         pkt_q     <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         beat_q    <= beat_d;
         hd_data_q <= hd_data_d;
         hd_last_q <= hd_last_d;
         tl_data_q <= tl_data_d;
         tl_last_q <= tl_last_d;
         pkt_q     <= pkt_d;
      end
   end

   assign fifo_rd   = push;
   assign m_valid   = (count_q != 2'd0);
   assign m_data    = hd_data_q;
   assign m_last    = hd_last_q;
   assign pkt_count = pkt_q;
   assign busy      = (state_q != IDLE) || (count_q != 2'd0);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: two reader instances (PKT_LEN=4 and PKT_LEN=1/CNT_W=2), each fed by a simple FIFO model.
module tb_fifo_stream_reader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0, m_ready = 1'b0;
   logic       enable1 = 1'b0, m_ready1 = 1'b0;
   logic       fifo_empty, fifo_rd, m_valid, m_last, busy;
   logic [7:0] fifo_r_data, m_data;
   logic [15:0] pkt_count;
   logic       fifo_empty1, fifo_rd1, m_valid1, m_last1, busy1;
   logic [7:0] fifo_r_data1, m_data1;
   logic [1:0] pkt_count1;

   logic [7:0] mem0 [0:63];
   logic [7:0] mem1 [0:63];
   int rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;
   logic flush0 = 1'b0;

   logic [7:0] rec_d [0:255];
   logic       rec_l [0:255];
   int         rec_c [0:255];
   int rec_n = 0, cyc = 0;

   int n_cmp = 0, n_err = 0;
   int base, rbase;

   fifo_stream_reader #(.B(8), .PKT_LEN(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_r_data(fifo_r_data), .fifo_rd(fifo_rd), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .pkt_count(pkt_count), .busy(busy));

   fifo_stream_reader #(.B(8), .PKT_LEN(1), .CNT_W(2)) dut1 (
      .clk(clk), .reset(reset), .enable(enable1), .fifo_empty(fifo_empty1),
      .fifo_r_data(fifo_r_data1), .fifo_rd(fifo_rd1), .m_valid(m_valid1),
      .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1),
      .pkt_count(pkt_count1), .busy(busy1));

   always #5 clk = ~clk;

   assign fifo_empty   = (rd0 == wr0);
   assign fifo_r_data  = mem0[rd0 % 64];
   assign fifo_empty1  = (rd1 == wr1);
   assign fifo_r_data1 = mem1[rd1 % 64];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (flush0) rd0 <= wr0;
      else if (fifo_rd) rd0 <= rd0 + 1;
      if (fifo_rd1) rd1 <= rd1 + 1;
   end

   // Log every word the downstream side accepts; inputs are stable mid-cycle.
   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         rec_d[rec_n % 256] <= m_data;
         rec_l[rec_n % 256] <= m_last;
         rec_c[rec_n % 256] <= cyc;
         rec_n <= rec_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [7:0] d);
      mem0[wr0 % 64] = d;
      wr0 = wr0 + 1;
   endtask

   task automatic push1(input logic [7:0] d);
      mem1[wr1 % 64] = d;
      wr1 = wr1 + 1;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      enable1 = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic flush();
      flush0 = 1'b1;
      tick();
      flush0 = 1'b0;
   endtask

   task automatic wait_pops(input int target, input int budget);
      int n = 0;
      while ((rd0 - base) < target && n < budget) begin
         tick();
         n++;
      end
      check("wait_pops", rd0 - base, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] exp6 [0:4];
      exp6[0] = 2'd1; exp6[1] = 2'd2; exp6[2] = 2'd3; exp6[3] = 2'd0; exp6[4] = 2'd1;

      do_reset();
      check("rst_valid", m_valid, 0);
      check("rst_rd", fifo_rd, 0);
      check("rst_busy", busy, 0);
      check("rst_pkt", pkt_count, 0);
      check("rst_data", m_data, 0);
      check("rst_last", m_last, 0);

      // Streaming: 8 words, two packets, full throughput
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) push0(8'h10 + 8'(i));
      rbase = rec_n;
      enable = 1'b1;
      tick();
      check("t1_first_rd", fifo_rd, 1);
      check("t1_first_valid", m_valid, 0);
      tick();
      check("t1_lat_valid", m_valid, 1);
      check("t1_lat_data", m_data, 8'h10);
      repeat (10) tick();
      enable = 1'b0;
      repeat (3) tick();
      check("t1_count", rec_n - rbase, 8);
      for (int i = 0; i < 8; i++) begin
         check("t1_data", rec_d[rbase + i], 8'h10 + 8'(i));
         check("t1_last", rec_l[rbase + i], (i == 3 || i == 7) ? 1 : 0);
      end
      check("t1_b2b", rec_c[rbase + 7] - rec_c[rbase], 7);
      check("t1_pkt", pkt_count, 2);
      check("t1_busy", busy, 0);

      // Backpressure
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) push0(8'h20 + 8'(i));
      base = rd0;
      rbase = rec_n;
      enable = 1'b1;
      repeat (6) tick();
      check("t2_pops", rd0 - base, 2);
      check("t2_rd", fifo_rd, 0);
      check("t2_valid", m_valid, 1);
      check("t2_hold", m_data, 8'h20);
      for (int n = 0; n < 60 && (rec_n - rbase) < 6; n++) begin
         m_ready = ~m_ready;
         tick();
      end
      m_ready = 1'b0;
      tick();
      check("t2_count", rec_n - rbase, 6);
      for (int i = 0; i < 6; i++) begin
         check("t2_data", rec_d[rbase + i], 8'h20 + 8'(i));
         check("t2_last", rec_l[rbase + i], (i == 3) ? 1 : 0);
      end
      check("t2_allpop", rd0 - base, 6);
      check("t2_pkt", pkt_count, 1);

      // Enable drop mid-packet finishes the packet, then stops
      do_reset();
      flush();
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) push0(8'h30 + 8'(i));
      base = rd0;
      rbase = rec_n;
      enable = 1'b1;
      wait_pops(2, 20);
      enable = 1'b0;
      tick();
      check("t3_busy_fin", busy, 1);
      repeat (6) tick();
      check("t3_pops", rd0 - base, 4);
      check("t3_rd", fifo_rd, 0);
      check("t3_left", wr0 - rd0, 6);
      check("t3_count", rec_n - rbase, 4);
      check("t3_last3", rec_l[rbase + 3], 1);
      check("t3_last1", rec_l[rbase + 1], 0);
      check("t3_busy", busy, 0);
      check("t3_pkt", pkt_count, 1);

      // Starvation while finishing a packet
      do_reset();
      flush();
      m_ready = 1'b1;
      push0(8'h40);
      base = rd0;
      rbase = rec_n;
      enable = 1'b1;
      wait_pops(1, 20);
      enable = 1'b0;
      repeat (4) tick();
      check("t4_rd", fifo_rd, 0);
      check("t4_busy", busy, 1);
      check("t4_pops", rd0 - base, 1);
      push0(8'h41); push0(8'h42); push0(8'h43);
      repeat (6) tick();
      check("t4_allpop", rd0 - base, 4);
      check("t4_count", rec_n - rbase, 4);
      check("t4_last2", rec_l[rbase + 2], 0);
      check("t4_last3", rec_l[rbase + 3], 1);
      check("t4_data3", rec_d[rbase + 3], 8'h43);
      check("t4_idle", busy, 0);
      check("t4_pkt", pkt_count, 1);

      // Reset mid-packet restarts alignment (word 0x52 is popped during the reset edge)
      do_reset();
      flush();
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) push0(8'h50 + 8'(i));
      base = rd0;
      enable = 1'b1;
      wait_pops(2, 20);
      reset = 1'b1;
      tick();
      check("t5_valid", m_valid, 0);
      check("t5_pkt0", pkt_count, 0);
      check("t5_busy", busy, 0);
      reset = 1'b0;
      rbase = rec_n;
      repeat (12) tick();
      check("t5_count", rec_n - rbase, 5);
      check("t5_first", rec_d[rbase], 8'h53);
      check("t5_last2", rec_l[rbase + 2], 0);
      check("t5_last3", rec_l[rbase + 3], 1);
      check("t5_data3", rec_d[rbase + 3], 8'h56);
      check("t5_last4", rec_l[rbase + 4], 0);
      check("t5_pkt", pkt_count, 1);

      // PKT_LEN=1, CNT_W=2: every word is a packet; counter wraps
      do_reset();
      m_ready1 = 1'b0;
      for (int i = 0; i < 5; i++) push1(8'h60 + 8'(i));
      enable1 = 1'b1;
      repeat (4) tick();
      for (int k = 0; k < 5; k++) begin
         check("t6_valid", m_valid1, 1);
         check("t6_data", m_data1, 8'h60 + 8'(k));
         check("t6_last", m_last1, 1);
         m_ready1 = 1'b1;
         tick();
         m_ready1 = 1'b0;
         check("t6_pkt", pkt_count1, exp6[k]);
      end
      enable1 = 1'b0;
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
